mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Multi-cycle M-stage memory access unit for the pipelined MIPS core.
- Sits between the M-stage and the system bridge (DM, timer0, timer1, interrupt generator).
- Accepts one load/store at a time and checks address alignment and range, raising AdEL or AdES.
- Drives a valid/ready bus request, sign- or zero-extends load data, and stalls the pipeline while busy.

Parameters:
- DM_END, 32'h0000_2fff, last byte address of data memory (DM starts at 0).
- T0_BASE, 32'h0000_7f00, timer0 base; the window is 12 bytes.
- T1_BASE, 32'h0000_7f10, timer1 base; the window is 12 bytes.
- IG_BASE, 32'h0000_7f20, interrupt-generator base; the window is 4 bytes.
- TIMEOUT_CYC, 16, maximum number of cycles spent in WAIT (used only with the optional feature).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- req_valid  in  1  M-stage request present
- req_ready  out  1  unit can accept a request (state IDLE)
- req_op  in  4  operation: LW, LH, LHU, LB, LBU, SW, SH, SB, NONE (encodings in the package)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- req_ovf  in  1  address-add overflow from the ALU
- flush  in  1  cancel the in-flight access (exception or eret)
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data, valid with resp_valid
- exc_adel  out  1  load address exception, valid with resp_valid
- exc_ades  out  1  store address exception, valid with resp_valid
- stall  out  1  pipeline hold
- bus_valid  out  1  bus request
- bus_ready  in  1  bus accepts the request
- bus_we  out  1  write enable
- bus_byteen  out  4  byte enables
- bus_addr  out  32  word-aligned address
- bus_wdata  out  32  lane-replicated store data
- bus_rvalid  in  1  read data returned
- bus_rdata  in  32  raw read word

Behaviour:
- Reset values: all outputs 0 except req_ready=1; state=IDLE.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE, on req_valid and req_op!=NONE, latches op, addr and wdata. An address check runs on the latched values:
  - Alignment: word requires addr[1:0]==0; half requires addr[0]==0.
  - Range: address outside DM, T0, T1 and IG windows is an error.
  - Half or byte access to a timer window is an error.
  - A store to a timer count register (offset 8) is an error.
  - req_ovf set is an error.
- Check outcome:
  - Error: go to DONE with exc_adel (load) or exc_ades (store); no bus access.
  - Otherwise: go to ISSUE.
- ISSUE: bus_valid=1, held stable until bus_ready.
  - Store: on handshake go to DONE.
  - Load: on handshake go to WAIT.
- WAIT: on bus_rvalid, latch the extended bus_rdata and go to DONE. bus_rvalid outside WAIT is ignored.
- DONE: resp_valid=1 for exactly one cycle, then IDLE.
- Minimum latency:
  - Exception: 2 cycles from accept.
  - Store: 2 cycles with bus_ready=1.
  - Load: 3 cycles with bus_ready=1 and bus_rvalid on the following cycle.
- Byte enables: SW 4'b1111; SH addr[1]?4'b1100:4'b0011; SB 4'b0001<<addr[1:0]. wdata is replicated per lane.
- Load extension: lane selected by addr[1:0]; LH and LB sign-extend; LHU and LBU zero-extend.
- stall = (state!=IDLE && state!=DONE) || (state==IDLE && accepting).
- Flush handling by state:
  - IDLE or DONE: suppress resp_valid and the exception outputs.
  - ISSUE before handshake: drop bus_valid, go to IDLE.
  - ISSUE with simultaneous handshake, or WAIT: set a discard flag, finish the bus protocol, skip DONE, return to IDLE.
- Reset mid-operation: immediate return to IDLE; bus_valid drops asynchronously.

Optional Feature:
- Macro: MAU_TIMEOUT_EN.
- Defined: a cycle counter runs in WAIT. After TIMEOUT_CYC cycles without bus_rvalid, go to DONE with exc_adel=1 and resp_rdata=0. A late bus_rvalid is ignored.
- Undefined: WAIT waits indefinitely and no counter logic exists.

Decomposition:
- Package mau_pkg: req_op encodings, state enum, region base/size constants, timer count-register offset.
- One combinational sub-module, mau_load_ext: (op, addr[1:0], raw word) -> extended data.

Test Plan:
- LW at 0x0000_0004, bus_rdata=0xdead_beef one cycle after handshake -> resp_valid on cycle 3, resp_rdata=0xdead_beef, no exception.
- LB at 0x0000_0013, bus_rdata=0x80aa_bbcc -> resp_rdata=0xffff_ff80. LBU at the same address -> resp_rdata=0x0000_0080.
- SH at 0x0000_0022, wdata=0x1234 -> bus_byteen=4'b1100, bus_wdata=0x1234_1234, bus_we=1, resp_valid without exception.
- The following must each give exc_adel=1 and no bus_valid: LW at 0x0000_0002; LH at 0x7f04; LW at 0x0000_3000. SW at 0x7f08 must give exc_ades=1 and no bus_valid.
- bus_ready low for 3 cycles, then flush asserted while in WAIT -> bus_valid stable during the stall, resp_valid never asserted, back in IDLE after bus_rvalid.
- With MAU_TIMEOUT_EN defined and no bus_rvalid -> exc_adel=1 after TIMEOUT_CYC=16 cycles in WAIT. Reset asserted mid-WAIT -> req_ready=1 immediately.

Source files
------------

// File: rtl/mau_pkg.sv
// Shared definitions for the M-stage memory access unit: op encodings, FSM states,
// address map constants and a window-membership helper.
package mau_pkg;

    typedef enum logic [3:0] {
        OP_NONE = 4'd0,
        OP_LW   = 4'd1,
        OP_LH   = 4'd2,
        OP_LHU  = 4'd3,
        OP_LB   = 4'd4,
        OP_LBU  = 4'd5,
        OP_SW   = 4'd6,
        OP_SH   = 4'd7,
        OP_SB   = 4'd8
    } mau_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } mau_state_e;

    localparam logic [31:0] DM_END      = 32'h0000_2fff;
    localparam logic [31:0] T0_BASE     = 32'h0000_7f00;
    localparam logic [31:0] T1_BASE     = 32'h0000_7f10;
    localparam logic [31:0] IG_BASE     = 32'h0000_7f20;
    localparam logic [31:0] TMR_SIZE    = 32'd12;
    localparam logic [31:0] IG_SIZE     = 32'd4;
    localparam logic [31:0] TMR_CNT_OFS = 32'd8;
    localparam int          TIMEOUT_CYC = 16;

    function automatic logic in_win(input logic [31:0] a, input logic [31:0] base,
                                    input logic [31:0] size);
        return (a >= base) && ((a - base) < size);
    endfunction

endpackage

// File: rtl/mau_load_ext.sv
// Load lane select and sign/zero extension; purely combinational.
module mau_load_ext
    import mau_pkg::*;
(
    input  logic [3:0]  op_i,
    input  logic [1:0]  lane_i,
    input  logic [31:0] raw_i,
    output logic [31:0] data_o
);

    logic [15:0] half_v;
    logic [7:0]  byte_v;

    always_comb begin
        half_v = lane_i[1] ? raw_i[31:16] : raw_i[15:0];
        case (lane_i)
            2'd0:    byte_v = raw_i[7:0];
            2'd1:    byte_v = raw_i[15:8];
            2'd2:    byte_v = raw_i[23:16];
            default: byte_v = raw_i[31:24];
        endcase

        case (op_i)
            OP_LH:   data_o = {{16{half_v[15]}}, half_v};
            OP_LHU:  data_o = {16'h0000, half_v};
            OP_LB:   data_o = {{24{byte_v[7]}}, byte_v};
            OP_LBU:  data_o = {24'h00_0000, byte_v};
            default: data_o = raw_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// M-stage load/store unit with address checks; optional WAIT timeout under MAU_TIMEOUT_EN.
// Latency from accept: 2 cycles for exceptions/stores, 3 for loads (zero-wait bus).
// Holds bus_valid and its fields stable until bus_ready; stalls the pipeline while busy.
module mem_access_unit
    import mau_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        req_ovf,
    input  logic        flush,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        exc_adel,
    output logic        exc_ades,
    output logic        stall,
    output logic        bus_valid,
    input  logic        bus_ready,
    output logic        bus_we,
    output logic [3:0]  bus_byteen,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    mau_state_e  state_q, state_d;
    logic [3:0]  op_q;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic        ovf_q, discard_q, discard_d;
    logic        accept, hshk, is_store, is_word, is_half;
    logic        in_dm, in_tmr, in_ig, addr_err;
    logic        tmo, tmo_flag;
    logic [31:0] ext_data;

    assign accept = (state_q == ST_IDLE) && req_valid && (req_op != OP_NONE) && !flush;

    // Address check works on the latched request and is evaluated in ISSUE.
    always_comb begin
        is_store = (op_q == OP_SW) || (op_q == OP_SH) || (op_q == OP_SB);
        is_word  = (op_q == OP_LW) || (op_q == OP_SW);
        is_half  = (op_q == OP_LH) || (op_q == OP_LHU) || (op_q == OP_SH);
        in_dm    = addr_q <= DM_END;
        in_tmr   = in_win(addr_q, T0_BASE, TMR_SIZE) || in_win(addr_q, T1_BASE, TMR_SIZE);
        in_ig    = in_win(addr_q, IG_BASE, IG_SIZE);
        addr_err = ovf_q
                || (is_word && (addr_q[1:0] != 2'b00))
                || (is_half && addr_q[0])
                || !(in_dm || in_tmr || in_ig)
                || (in_tmr && !is_word)
                || (in_tmr && is_store && ((addr_q == T0_BASE + TMR_CNT_OFS)
                                        || (addr_q == T1_BASE + TMR_CNT_OFS)));
    end

    assign bus_valid = (state_q == ST_ISSUE) && !addr_err;
    assign hshk      = bus_valid && bus_ready;

`ifdef MAU_TIMEOUT_EN
    localparam int            TW       = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
    logic [TW-1:0] cnt_q;
    logic          tmo_q;

    assign tmo      = (state_q == ST_WAIT) && !bus_rvalid && (cnt_q == TMO_LAST);
    assign tmo_flag = tmo_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            tmo_q <= 1'b0;
        end else begin
            cnt_q <= (state_q == ST_WAIT) ? cnt_q + 1'b1 : '0;
            if (accept)
                tmo_q <= 1'b0;
            else if (tmo)
                tmo_q <= 1'b1;
        end
    end
`else
    assign tmo      = 1'b0;
    assign tmo_flag = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        discard_d = discard_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d   = ST_ISSUE;
                    discard_d = 1'b0;
                end
            end
            ST_ISSUE: begin
                if (addr_err)
                    state_d = flush ? ST_IDLE : ST_DONE;
                else if (hshk) begin
                    // A flushed load still has to absorb its read return.
                    if (is_store)
                        state_d = flush ? ST_IDLE : ST_DONE;
                    else begin
                        state_d   = ST_WAIT;
                        discard_d = flush;
                    end
                end else if (flush)
                    state_d = ST_IDLE;
            end
            ST_WAIT: begin
                if (flush)
                    discard_d = 1'b1;
                if (bus_rvalid || tmo)
                    state_d = (discard_q || flush) ? ST_IDLE : ST_DONE;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    mau_load_ext u_load_ext (
        .op_i   (op_q),
        .lane_i (addr_q[1:0]),
        .raw_i  (bus_rdata),
        .data_o (ext_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            discard_q <= 1'b0;
            op_q      <= 4'd0;
            addr_q    <= '0;
            wdata_q   <= '0;
            ovf_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            discard_q <= discard_d;
            if (accept) begin
                op_q    <= req_op;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                ovf_q   <= req_ovf;
                rdata_q <= '0;
            end else if ((state_q == ST_WAIT) && bus_rvalid) begin
                rdata_q <= ext_data;
            end
        end
    end

    always_comb begin
        bus_addr   = '0;
        bus_we     = 1'b0;
        bus_byteen = 4'b0000;
        bus_wdata  = '0;
        if (bus_valid) begin
            bus_addr = {addr_q[31:2], 2'b00};
            bus_we   = is_store;
            if (is_word)
                bus_byteen = 4'b1111;
            else if (is_half)
                bus_byteen = addr_q[1] ? 4'b1100 : 4'b0011;
            else
                bus_byteen = 4'b0001 << addr_q[1:0];
            if (is_store)
                bus_wdata = is_word ? wdata_q :
                            is_half ? {2{wdata_q[15:0]}} : {4{wdata_q[7:0]}};
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_DONE) && !flush;
    assign resp_rdata = rdata_q;
    assign exc_adel   = resp_valid && !is_store && (addr_err || tmo_flag);
    assign exc_ades   = resp_valid && is_store && addr_err;
    assign stall      = (state_q == ST_ISSUE) || (state_q == ST_WAIT) || accept;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed vector table, corner sequences, random traffic.
`timescale 1ns/1ps
module tb_mem_access_unit;
    import mau_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_ovf, flush;
    logic [3:0]  req_op;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, exc_adel, exc_ades, stall;
    logic [31:0] resp_rdata;
    logic        bus_valid, bus_ready, bus_we, bus_rvalid;
    logic [3:0]  bus_byteen;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ovf(req_ovf), .flush(flush),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .exc_adel(exc_adel), .exc_ades(exc_ades), .stall(stall),
        .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_we(bus_we),
        .bus_byteen(bus_byteen), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int          lat;
        logic        saw_bus, unstable, stall_acc, we, adel, ades;
        logic [31:0] baddr, bwdata, rdata;
        logic [3:0]  be;
    } obs_t;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr, wdata, raw;
        logic        ovf, err;
        logic [31:0] rd, bwd;
        logic [3:0]  be;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, want %08h", name, act, exp);
        end
    endtask

    function automatic logic is_st(input logic [3:0] op);
        return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
    endfunction

    function automatic int acc_size(input logic [3:0] op);
        if (op == OP_LW || op == OP_SW) return 4;
        if (op == OP_LH || op == OP_LHU || op == OP_SH) return 2;
        return 1;
    endfunction

    // Reference: address map and data rules written as plain arithmetic.
    function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] wd,
                                  input logic ovf, input logic [31:0] raw, output logic err,
                                  output logic [31:0] rd, output logic [3:0] be, output logic [31:0] bwd);
        int          sz   = acc_size(op);
        int          lane = int'(a[1:0]);
        int          be_i;
        logic        dm, tmr, ig, sgn;
        logic [31:0] mask;
        dm  = a <= 32'h2fff;
        tmr = (a >= 32'h7f00 && a < 32'h7f0c) || (a >= 32'h7f10 && a < 32'h7f1c);
        ig  = (a >= 32'h7f20 && a < 32'h7f24);
        err = ovf || ((lane % sz) != 0) || !(dm || tmr || ig) || (tmr && sz != 4)
           || (tmr && is_st(op) && (a & 32'hf) == 32'h8);
        be_i = ((1 << sz) - 1) << lane;
        be   = be_i[3:0];
        bwd  = (sz == 4) ? wd : (sz == 2) ? 32'(wd[15:0]) * 32'h0001_0001 : 32'(wd[7:0]) * 32'h0101_0101;
        mask = (sz == 4) ? 32'hffff_ffff : ((32'h1 << (8 * sz)) - 32'h1);
        rd   = (raw >> (8 * lane)) & mask;
        sgn  = (op == OP_LH) || (op == OP_LB);
        if (sgn && rd[8 * sz - 1]) rd = rd | ~mask;
        if (err) rd = '0;
    endfunction

    task automatic add_vec(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic ovf, input logic [31:0] raw, input logic err,
                           input logic [31:0] rd, input logic [3:0] be, input logic [31:0] bwd);
        vec_t v;
        v.op = op; v.addr = addr; v.wdata = wdata; v.ovf = ovf; v.raw = raw;
        v.err = err; v.rd = rd; v.be = be; v.bwd = bwd;
        vecs.push_back(v);
    endtask

    // Called just after a rising edge with the unit idle; acts as a responsive bus slave.
    task automatic run_txn(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic ovf, input logic [31:0] raw, input int rdy_dly,
                           input int rv_dly, output obs_t o);
        int   hs;
        logic done;
        o = '{default: 0};
        o.lat = -1;
        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata; req_ovf = ovf;
        @(negedge clk);
        o.stall_acc = stall;
        @(posedge clk); #1;
        req_valid = 1'b0; req_op = OP_NONE;
        hs = -1; done = 1'b0;
        for (int k = 1; k <= 60 && !done; k++) begin
            bus_ready  = (k > rdy_dly);
            bus_rvalid = (hs > 0) && (k == hs + 1 + rv_dly);
            bus_rdata  = raw;
            @(negedge clk);
            if (bus_valid) begin
                if (!o.saw_bus) begin
                    o.saw_bus = 1'b1; o.baddr = bus_addr; o.be = bus_byteen;
                    o.bwdata = bus_wdata; o.we = bus_we;
                end else if (bus_addr !== o.baddr || bus_byteen !== o.be
                          || bus_wdata !== o.bwdata || bus_we !== o.we)
                    o.unstable = 1'b1;
                if (bus_ready && hs < 0) hs = k;
            end
            if (resp_valid) begin
                o.lat = k; o.rdata = resp_rdata; o.adel = exc_adel; o.ades = exc_ades;
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        bus_ready = 1'b0; bus_rvalid = 1'b0;
    endtask

    task automatic verify(input string tag, input logic [3:0] op, input logic [31:0] addr,
                          input int rdy, input int rv, input logic err, input logic [31:0] rd,
                          input logic [3:0] be, input logic [31:0] bwd, input obs_t o);
        logic st = is_st(op);
        int   exp_lat = err ? 2 : st ? rdy + 2 : rdy + rv + 3;
        chk({tag, "_lat"},   o.lat, exp_lat);
        chk({tag, "_stall"}, o.stall_acc, 1);
        chk({tag, "_bus"},   o.saw_bus, !err);
        chk({tag, "_adel"},  o.adel, err && !st);
        chk({tag, "_ades"},  o.ades, err && st);
        if (!err) begin
            chk({tag, "_baddr"},  o.baddr, addr & 32'hffff_fffc);
            chk({tag, "_we"},     o.we, st);
            chk({tag, "_stable"}, o.unstable, 0);
            if (st) begin
                chk({tag, "_be"},  o.be, be);
                chk({tag, "_bwd"}, o.bwdata, bwd);
            end else
                chk({tag, "_rdata"}, o.rdata, rd);
        end
    endtask

    initial begin
        obs_t        o;
        logic        saw;
        logic        e;
        logic [31:0] a, wd, raw, rd, bwd;
        logic [3:0]  op, be;
        int          rdy, rv;

        reset = 1'b1; req_valid = 1'b0; req_op = OP_NONE; req_addr = '0; req_wdata = '0;
        req_ovf = 1'b0; flush = 1'b0; bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
        #2;
        chk("rst_ready", req_ready, 1);
        chk("rst_outs", {resp_valid, exc_adel, exc_ades, stall, bus_valid, bus_we, bus_byteen}, 0);
        chk("rst_rdata", resp_rdata, 0);
        chk("rst_baddr", bus_addr, 0);
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1;

        //      op      addr          wdata         ovf  raw           err  rd            be       bwd
        add_vec(OP_LW,  32'h0000_0004, 32'h0,        0, 32'hdead_beef, 0, 32'hdead_beef, 4'hf,    32'h0);
        add_vec(OP_LB,  32'h0000_0013, 32'h0,        0, 32'h80aa_bbcc, 0, 32'hffff_ff80, 4'h8,    32'h0);
        add_vec(OP_LBU, 32'h0000_0013, 32'h0,        0, 32'h80aa_bbcc, 0, 32'h0000_0080, 4'h8,    32'h0);
        add_vec(OP_LH,  32'h0000_0012, 32'h0,        0, 32'h80aa_bbcc, 0, 32'hffff_80aa, 4'hc,    32'h0);
        add_vec(OP_LHU, 32'h0000_0010, 32'h0,        0, 32'h80aa_bbcc, 0, 32'h0000_bbcc, 4'h3,    32'h0);
        add_vec(OP_SH,  32'h0000_0022, 32'h1234,     0, 32'h0,         0, 32'h0,         4'b1100, 32'h1234_1234);
        add_vec(OP_SB,  32'h0000_0021, 32'h00a5,     0, 32'h0,         0, 32'h0,         4'b0010, 32'ha5a5_a5a5);
        add_vec(OP_SB,  32'h0000_2fff, 32'h005a,     0, 32'h0,         0, 32'h0,         4'b1000, 32'h5a5a_5a5a);
        add_vec(OP_SW,  32'h0000_7f20, 32'h3,        0, 32'h0,         0, 32'h0,         4'hf,    32'h3);
        add_vec(OP_LW,  32'h0000_7f08, 32'h0,        0, 32'h0000_0055, 0, 32'h0000_0055, 4'hf,    32'h0);
        add_vec(OP_LW,  32'h0000_2ffc, 32'h0,        0, 32'h0102_0304, 0, 32'h0102_0304, 4'hf,    32'h0);
        add_vec(OP_LB,  32'h0000_7f23, 32'h0,        0, 32'h7f00_0000, 0, 32'h0000_007f, 4'h8,    32'h0);
        add_vec(OP_LW,  32'h0000_0002, 32'h0,        0, 32'h0,         1, 32'h0,         4'h0,    32'h0);
        add_vec(OP_LH,  32'h0000_7f04, 32'h0,        0, 32'h0,         1, 32'h0,         4'h0,    32'h0);
        add_vec(OP_LW,  32'h0000_3000, 32'h0,        0, 32'h0,         1, 32'h0,         4'h0,    32'h0);
        add_vec(OP_SW,  32'h0000_7f08, 32'h1,        0, 32'h0,         1, 32'h0,         4'h0,    32'h0);
        add_vec(OP_LW,  32'h0000_7f0c, 32'h0,        0, 32'h0,         1, 32'h0,         4'h0,    32'h0);
        add_vec(OP_LW,  32'h0000_0004, 32'h0,        1, 32'h0,         1, 32'h0,         4'h0,    32'h0);

        foreach (vecs[i]) begin
            run_txn(vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].ovf, vecs[i].raw, 0, 0, o);
            verify($sformatf("vec%0d", i), vecs[i].op, vecs[i].addr, 0, 0, vecs[i].err,
                   vecs[i].rd, vecs[i].be, vecs[i].bwd, o);
        end

        // Flush while WAIT after a 3-cycle bus_ready stall: response dropped, read absorbed.
        req_valid = 1'b1; req_op = OP_LW; req_addr = 32'h8; req_ovf = 1'b0;
        @(posedge clk); #1 req_valid = 1'b0; req_op = OP_NONE;
        saw = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            bus_ready = (k == 4); flush = (k == 5); bus_rvalid = (k == 7);
            @(negedge clk);
            if (resp_valid) saw = 1'b1;
            if (k <= 4) begin
                chk("flw_bvalid", bus_valid, 1);
                chk("flw_baddr", bus_addr, 32'h8);
            end
            if (k == 7) chk("flw_busy", req_ready, 0);
            if (k == 8) chk("flw_idle", req_ready, 1);
            @(posedge clk); #1;
        end
        flush = 1'b0; bus_ready = 1'b0; bus_rvalid = 1'b0;
        chk("flw_no_resp", saw, 0);

        // Flush in ISSUE before handshake drops the request.
        req_valid = 1'b1; req_op = OP_SW; req_addr = 32'h10; req_wdata = 32'h77;
        @(posedge clk); #1 req_valid = 1'b0; req_op = OP_NONE; flush = 1'b1;
        @(negedge clk); chk("fli_bvalid", bus_valid, 1);
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        chk("fli_idle", req_ready, 1);
        chk("fli_drop", {bus_valid, resp_valid}, 0);
        @(posedge clk); #1;

        // Flush in DONE suppresses the exception response.
        req_valid = 1'b1; req_op = OP_LW; req_addr = 32'h2;
        @(posedge clk); #1 req_valid = 1'b0; req_op = OP_NONE;
        @(posedge clk); #1 flush = 1'b1;
        @(negedge clk); chk("fld_quiet", {resp_valid, exc_adel, exc_ades}, 0);
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk); chk("fld_idle", req_ready, 1);
        @(posedge clk); #1;

        // Asynchronous reset in ISSUE and in WAIT.
        req_valid = 1'b1; req_op = OP_SW; req_addr = 32'h14; bus_ready = 1'b0;
        @(posedge clk); #1 req_valid = 1'b0; req_op = OP_NONE;
        @(negedge clk); chk("rsi_bvalid", bus_valid, 1);
        reset = 1'b1; #1;
        chk("rsi_drop", bus_valid, 0);
        chk("rsi_ready", req_ready, 1);
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b1; req_op = OP_LW; req_addr = 32'h4; bus_ready = 1'b1;
        @(posedge clk); #1 req_valid = 1'b0; req_op = OP_NONE;
        @(posedge clk); #1 bus_ready = 1'b0;
        @(negedge clk); chk("rsw_busy", {req_ready, stall}, 2'b01);
        reset = 1'b1; #1;
        chk("rsw_ready", req_ready, 1);
        chk("rsw_stall", stall, 0);
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1;

`ifdef MAU_TIMEOUT_EN
        run_txn(OP_LW, 32'h4, 32'h0, 1'b0, 32'hffff_ffff, 0, 1000, o);
        chk("tmo_lat", o.lat, 18);
        chk("tmo_adel", o.adel, 1);
        chk("tmo_rdata", o.rdata, 0);
        bus_rvalid = 1'b1;
        @(negedge clk); chk("tmo_late", {resp_valid, req_ready}, 2'b01);
        @(posedge clk); #1 bus_rvalid = 1'b0;
        @(negedge clk); chk("tmo_late2", resp_valid, 0);
        @(posedge clk); #1;
`else
        run_txn(OP_LHU, 32'h6, 32'h0, 1'b0, 32'hc3c3_1111, 0, 20, o);
        chk("slow_lat", o.lat, 23);
        chk("slow_rdata", o.rdata, 32'h0000_c3c3);
`endif

        for (int i = 0; i < 150; i++) begin
            op = 4'($urandom_range(1, 8));
            case ($urandom_range(0, 3))
                0:       a = 32'($urandom_range(0, 32'h2fff));
                1:       a = 32'h7f00 + 32'($urandom_range(0, 32'h2f));
                2:       a = 32'h2ff0 + 32'($urandom_range(0, 32'h1f));
                default: a = $urandom;
            endcase
            if ($urandom_range(0, 1) == 1) a = a & ~(32'(acc_size(op)) - 32'h1);
            wd  = $urandom;
            raw = $urandom;
            rdy = $urandom_range(0, 2);
            rv  = $urandom_range(0, 2);
            model(op, a, wd, ($urandom_range(0, 15) == 0), raw, e, rd, be, bwd);
            run_txn(op, a, wd, e && ($urandom_range(0, 1) == 0) ? 1'b0 : 1'b0, raw, rdy, rv, o);
            // ovf kept 0 here so the model's verdict stays tied to the address rules
            model(op, a, wd, 1'b0, raw, e, rd, be, bwd);
            verify($sformatf("rnd%0d", i), op, a, rdy, rv, e, rd, be, bwd, o);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
